npc_motion_ctrl: RTL and testbench

Parametrised successor to the single-NPC mover. It drives one computer-controlled player on its half-court, chasing the ball horizontally and performing gravity-accurate jumps.
- Uses a frame-tick-paced state machine with signed fixed-point vertical velocity.
- Every constant is a parameter: court bounds, sprite size, jump strength, gravity, run speed, jump trigger window.
- Sits between ball physics and the sprite renderer.
- Outputs integer pixel positions in VBUF (320x240) coordinates.

---
 rtl/npc_pkg.sv | 11 +
 rtl/npc_motion_ctrl_if.sv | 15 +
 rtl/npc_tick_gen.sv | 17 +
 rtl/npc_motion_ctrl.sv | 119 +++++++++++
 tb/tb_npc_motion_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared constants, fixed-point widths and vertical state encoding for the NPC mover.
package npc_pkg;
    localparam int FRAC_W = 8;
    localparam int POS_W  = 12;
    localparam int FP_W   = POS_W + FRAC_W;
    localparam int VBUF_W = 320;
    localparam int VBUF_H = 240;
    localparam int NPC_W  = 41;
    localparam int NPC_H  = 42;
    typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2, LAND = 2'd3} npc_state_t;
endpackage

// File: rtl/npc_motion_ctrl_if.sv
// npc_motion_ctrl_if: ball-in / sprite-out bundle between ball physics, NPC mover and renderer.
interface npc_motion_if;
    logic        enable;
    logic [11:0] ball_pos_x;
    logic [11:0] ball_pos_y;
    logic [7:0]  ball_vel_x;
    logic [11:0] npc_pos_x;
    logic [11:0] npc_pos_y;
    logic [1:0]  npc_state;
    logic        tick;
    modport master (output enable, ball_pos_x, ball_pos_y, ball_vel_x,
                    input  npc_pos_x, npc_pos_y, npc_state, tick);
    modport slave  (input  enable, ball_pos_x, ball_pos_y, ball_vel_x,
                    output npc_pos_x, npc_pos_y, npc_state, tick);
endinterface

// File: rtl/npc_tick_gen.sv
// npc_tick_gen: frame-rate divider; tick_o pulses for one cycle every TICK_DIV enabled cycles.
module npc_tick_gen #(
    parameter int TICK_DIV = 416667
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable_i,
    output logic tick_o
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick_o = enable_i && cnt_q == CW'(TICK_DIV - 1);
    assign cnt_d  = !enable_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
endmodule

// File: rtl/npc_motion_ctrl.sv
// npc_motion_ctrl: tick-paced NPC chase and gravity jump with fixed-point vertical motion.
// Define NPC_PREDICT_EN to chase a velocity-extrapolated ball target instead of ball_pos_x.
module npc_motion_ctrl #(
    parameter int FRAC_W      = npc_pkg::FRAC_W,
    parameter int VBUF_W      = npc_pkg::VBUF_W,
    parameter int NPC_W       = npc_pkg::NPC_W,
    parameter int NPC_H       = npc_pkg::NPC_H,
    parameter int X_MIN       = 160,
    parameter int X_MAX       = 320,
    parameter int GROUND_Y    = 177,
    parameter int TICK_DIV    = 416667,
    parameter int RUN_STEP    = 2,
    parameter int DEAD_ZONE   = 4,
    parameter int JUMP_V      = 1536,
    parameter int GRAVITY     = 64,
    parameter int VMAX        = 2048,
    parameter int JUMP_TRIG_Y = 120,
    parameter int JUMP_WIN    = 40,
    parameter int COOLDOWN    = 8,
    parameter int PRED_SHIFT  = 3
) (
    input logic         clk,
    input logic         reset_n,
    npc_motion_if.slave bus
);
    import npc_pkg::*;
    localparam int FPW = 12 + FRAC_W;
    localparam int XR  = X_MAX - NPC_W;
    localparam logic [FPW-1:0] Y_GND = FPW'(GROUND_Y << FRAC_W);
    logic                  tick;
    logic [11:0]           x_q, x_d, x_mv;
    logic [FPW-1:0]        y_q, y_d, y_dn;
    logic signed [FPW-1:0] vy_q, vy_d, vy_dec, vy_add;
    npc_state_t            st_q, st_d;
    logic [7:0]            cd_q, cd_d;
    logic [12:0]           tgt, ctr, xr;
    logic                  jump, landed, rise_end;
    npc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable_i (bus.enable),
        .tick_o   (tick)
    );
`ifdef NPC_PREDICT_EN
    logic signed [13:0] vel_ext, pred;
    assign vel_ext = 14'(signed'(bus.ball_vel_x));
    assign pred    = $signed({2'b00, bus.ball_pos_x}) + (vel_ext <<< PRED_SHIFT);
    assign tgt     = pred[13] ? '0 : pred > $signed(14'(VBUF_W - 1)) ? 13'(VBUF_W - 1) : 13'(pred);
`else
    assign tgt = {1'b0, bus.ball_pos_x};
`endif
    // All horizontal compares are 13-bit unsigned with offsets on the other side, so nothing wraps below 0.
    assign ctr  = {1'b0, x_q} + 13'(NPC_W / 2);
    assign xr   = {1'b0, x_q} + 13'(RUN_STEP);
    assign x_mv = tgt > ctr + 13'(DEAD_ZONE) ? (xr > 13'(XR) ? 12'(XR) : xr[11:0])
                : tgt + 13'(DEAD_ZONE) < ctr ? ({1'b0, x_q} >= 13'(X_MIN + RUN_STEP) ? x_q - 12'(RUN_STEP) : 12'(X_MIN))
                : x_q;
    assign jump     = bus.ball_pos_y <= 12'(JUMP_TRIG_Y) && tgt + 13'(JUMP_WIN) >= ctr && tgt <= ctr + 13'(JUMP_WIN);
    assign vy_dec   = vy_q - FPW'(GRAVITY);
    assign vy_add   = vy_q + FPW'(GRAVITY);
    assign rise_end = vy_dec[FPW-1] || vy_dec == '0;
    assign y_dn     = y_q + $unsigned(vy_q);
    assign landed   = y_dn[FPW-1:FRAC_W] >= 12'(GROUND_Y);
    always_comb begin
        x_d  = tick ? x_mv : x_q;
        y_d  = y_q;
        vy_d = vy_q;
        st_d = st_q;
        cd_d = cd_q;
        if (tick)
            case (st_q)
                GROUND: if (jump) begin
                    vy_d = FPW'(JUMP_V);
                    st_d = RISE;
                end
                RISE: if (y_q < $unsigned(vy_q)) begin
                    y_d  = '0;
                    vy_d = '0;
                    st_d = FALL;
                end else begin
                    y_d  = y_q - $unsigned(vy_q);
                    vy_d = rise_end ? '0 : vy_dec;
                    st_d = rise_end ? FALL : RISE;
                end
                FALL: if (landed) begin
                    y_d  = Y_GND;
                    vy_d = '0;
                    cd_d = 8'(COOLDOWN);
                    st_d = LAND;
                end else begin
                    y_d  = y_dn;
                    vy_d = vy_add > $signed(FPW'(VMAX)) ? FPW'(VMAX) : vy_add;
                end
                LAND: begin
                    cd_d = cd_q == '0 ? '0 : cd_q - 1'b1;
                    st_d = cd_q <= 8'd1 ? GROUND : LAND;
                end
                default: ;
            endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            x_q  <= 12'(XR - 1);
            y_q  <= Y_GND;
            vy_q <= '0;
            st_q <= GROUND;
            cd_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            vy_q <= vy_d;
            st_q <= st_d;
            cd_q <= cd_d;
        end
    assign bus.npc_pos_x = x_q;
    assign bus.npc_pos_y = y_q[FPW-1:FRAC_W];
    assign bus.npc_state = st_q;
    assign bus.tick      = tick;
endmodule

// File: tb/tb_npc_motion_ctrl.sv
// tb_npc_motion_ctrl: directed scoreboard bench for npc_motion_ctrl with TICK_DIV=4.
module tb_npc_motion_ctrl;
    typedef struct {
        int    t;
        int    x;
        int    y;
        int    st;
        string name;
    } exp_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   nticks = 0;
    exp_t q[$];
    always #5 clk = ~clk;
    npc_motion_if bus();
    npc_motion_ctrl #(.TICK_DIV(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );
    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask
    task automatic push_exp(input int dt, input int x, input int y, input int st, input string nm);
        exp_t e;
        e.t = nticks + dt;
        e.x = x;
        e.y = y;
        e.st = st;
        e.name = nm;
        q.push_back(e);
    endtask
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int s = nticks;
            int c = 0;
            while (nticks == s && c < 50) begin
                @(posedge clk);
                #2;
                c++;
            end
            if (nticks == s) begin
                checks++;
                errors++;
                $display("FAIL tick_timeout: got no tick in %0d cycles expected one", c);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    endtask
    // Monitor: on every completed tick, compare any expectation due at this tick count.
    initial begin : monitor
        logic tk;
        exp_t e;
        forever begin
            @(negedge clk);
            tk = bus.tick;
            @(posedge clk);
            if (tk) begin
                #1;
                nticks++;
                while (q.size() > 0 && q[0].t <= nticks) begin
                    e = q.pop_front();
                    check({e.name, "_when"}, e.t, nticks);
                    check({e.name, "_x"}, int'(bus.npc_pos_x), e.x);
                    check({e.name, "_y"}, int'(bus.npc_pos_y), e.y);
                    check({e.name, "_st"}, int'(bus.npc_state), e.st);
                end
            end
        end
    end
    initial begin : stim
        int pulses;
        bus.enable = 1'b1;
        bus.ball_pos_x = 12'd300;
        bus.ball_pos_y = 12'd230;
        bus.ball_vel_x = 8'd0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_x", int'(bus.npc_pos_x), 278);
        check("rst_y", int'(bus.npc_pos_y), 177);
        check("rst_st", int'(bus.npc_state), 0);
        check("rst_tick", int'(bus.tick), 0);
        reset_n = 1'b1;
        push_exp(1, 278, 177, 0, "deadzone_hold");
        wait_ticks(1);
        bus.ball_pos_x = 12'd310;
        push_exp(1, 279, 177, 0, "clamp_right");
        push_exp(2, 279, 177, 0, "clamp_hold");
        wait_ticks(2);
        bus.ball_pos_x = 12'd0;
        push_exp(1, 277, 177, 0, "run_left");
        push_exp(59, 161, 177, 0, "run_left_59");
        push_exp(60, 160, 177, 0, "clamp_left");
        push_exp(62, 160, 177, 0, "clamp_left_hold");
        wait_ticks(62);
        bus.ball_pos_x = 12'd190;
        bus.ball_pos_y = 12'd100;
        push_exp(1, 162, 177, 1, "jump");
        wait_ticks(1);
        bus.ball_pos_y = 12'd230;
        push_exp(1, 164, 171, 1, "rise1");
        push_exp(2, 166, 165, 1, "rise2");
        push_exp(23, 166, 102, 1, "rise23");
        push_exp(24, 166, 102, 2, "apex");
        push_exp(48, 166, 171, 2, "fall24");
        push_exp(49, 166, 177, 3, "land");
        push_exp(56, 166, 177, 3, "land7");
        push_exp(57, 166, 177, 0, "ground");
        push_exp(58, 166, 177, 0, "ground_nojump");
        wait_ticks(58);
        bus.ball_pos_y = 12'd100;
        push_exp(1, 166, 177, 1, "jump2");
        push_exp(11, 166, 128, 1, "rise10");
        wait_ticks(11);
        bus.ball_pos_x = 12'd300;
        bus.ball_pos_y = 12'd230;
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_x", int'(bus.npc_pos_x), 278);
        check("async_rst_y", int'(bus.npc_pos_y), 177);
        check("async_rst_st", int'(bus.npc_state), 0);
        check("async_rst_tick", int'(bus.tick), 0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        bus.ball_pos_y = 12'd100;
        push_exp(1, 278, 177, 1, "jump3");
        wait_ticks(1);
        bus.ball_pos_y = 12'd230;
        push_exp(24, 278, 102, 2, "apex3");
        push_exp(29, 278, 104, 2, "pre_freeze");
        wait_ticks(29);
        bus.enable = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tick) pulses++;
        end
        check("freeze_tick", pulses, 0);
        check("freeze_x", int'(bus.npc_pos_x), 278);
        check("freeze_y", int'(bus.npc_pos_y), 104);
        check("freeze_st", int'(bus.npc_state), 2);
        bus.enable = 1'b1;
        push_exp(1, 278, 105, 2, "resume");
        push_exp(20, 278, 177, 3, "land3");
        wait_ticks(20);
        bus.ball_pos_x = 12'd224;
        bus.ball_vel_x = 8'd5;
`ifdef NPC_PREDICT_EN
        push_exp(40, 248, 177, 0, "predict");
`else
        push_exp(40, 208, 177, 0, "predict");
`endif
        wait_ticks(40);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
